// File: rtl/ppu_types_pkg.sv
// Shared PPU-side types and constants.
// Holds the OAM DMA state encoding, the transfer length and the echo-RAM fold
// used when mapping the FF46 source page onto the system bus.
package ppu_types_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } oam_dma_state_t;

    localparam int         OAM_DMA_BYTES   = 160;
    localparam logic [7:0] DMA_ECHO_BASE   = 8'hE0;
    localparam logic [7:0] DMA_ECHO_OFFSET = 8'h20;

    // Source pages E0..FF mirror C0..DF (echo RAM), so FE reads DE and FF reads DF.
    function automatic logic [7:0] dma_fold_src(input logic [7:0] src_hi);
        return (src_hi >= DMA_ECHO_BASE) ? (src_hi - DMA_ECHO_OFFSET) : src_hi;
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA controller.
// A CPU write to FF46 starts a copy of OAM_BYTES bytes from page {src_hi,8'h00}
// into PPU OAM, one byte every DOTS_PER_BYTE clocks after a START_DELAY-clock
// start delay. A new write during a transfer restarts it from byte 0.
// Build option: define OAM_DMA_READBACK_EN to make FF46 read back the last
// written value; otherwise FF46 reads as open bus (8'hFF).
module oam_dma_controller
    import ppu_types_pkg::*;
#(
    parameter int OAM_BYTES     = OAM_DMA_BYTES,
    parameter int DOTS_PER_BYTE = 4,
    parameter int START_DELAY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        src_read_en,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_waddr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic        busy
);

    localparam int SUB_W   = $clog2(DOTS_PER_BYTE);
    localparam int START_W = $clog2(START_DELAY + 1);

    localparam logic [SUB_W-1:0]   LAST_SUB   = SUB_W'(DOTS_PER_BYTE - 1);
    localparam logic [START_W-1:0] LAST_START = START_W'(START_DELAY - 1);
    localparam logic [7:0]         LAST_BYTE  = 8'(OAM_BYTES - 1);

    oam_dma_state_t     state_q,     state_d;
    logic [START_W-1:0] start_cnt_q, start_cnt_d;
    logic [SUB_W-1:0]   sub_cnt_q,   sub_cnt_d;
    logic [7:0]         byte_idx_q,  byte_idx_d;
    logic [7:0]         src_hi_q,    src_hi_d;
    logic [7:0]         data_q,      data_d;
    logic               restart_q,   restart_d;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!reset_n) begin
            state_q     <= DMA_IDLE;
            start_cnt_q <= '0;
            sub_cnt_q   <= '0;
            byte_idx_q  <= '0;
            src_hi_q    <= '0;
            data_q      <= '0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            byte_idx_q  <= byte_idx_d;
            src_hi_q    <= src_hi_d;
            data_q      <= data_d;
            restart_q   <= restart_d;
        end
    end

    // Next-state, counter updates and per-cycle bus strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        byte_idx_d  = byte_idx_q;
        src_hi_d    = src_hi_q;
        data_d      = data_q;
        restart_d   = restart_q;
        src_read_en = 1'b0;
        src_addr    = '0;
        oam_we      = 1'b0;
        oam_waddr   = '0;
        oam_wdata   = '0;

        case (state_q)
            DMA_IDLE: begin
            end
            DMA_START: begin
                if (start_cnt_q == LAST_START) begin
                    state_d    = DMA_XFER;
                    sub_cnt_d  = '0;
                    byte_idx_d = '0;
                    restart_d  = 1'b0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            DMA_XFER: begin
                // Source byte is fetched on the first dot of each M-cycle.
                if (sub_cnt_q == '0) begin
                    src_read_en = 1'b1;
                    src_addr    = {dma_fold_src(src_hi_q), byte_idx_q};
                    data_d      = src_rdata;
                end
                // OAM write happens on the last dot, then the byte index advances.
                if (sub_cnt_q == LAST_SUB) begin
                    oam_we    = 1'b1;
                    oam_waddr = byte_idx_q;
                    oam_wdata = data_q;
                    sub_cnt_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = DMA_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                    end
                end else begin
                    sub_cnt_d = sub_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase

        // A write to FF46 always (re)starts the sequence; a write pending this
        // cycle has already been driven above and still lands in OAM.
        if (reg_we) begin
            state_d     = DMA_START;
            src_hi_d    = reg_wdata;
            start_cnt_d = '0;
            sub_cnt_d   = '0;
            byte_idx_d  = '0;
            if (state_q == DMA_XFER) begin
                restart_d = 1'b1;
            end
        end
    end

    // Bus blocking stays asserted across a restart so the CPU never sneaks in.
    assign dma_active = (state_q == DMA_XFER) || ((state_q == DMA_START) && restart_q);
    assign busy       = (state_q != DMA_IDLE);

`ifdef OAM_DMA_READBACK_EN
    assign reg_rdata = src_hi_q;
`else
    assign reg_rdata = 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller.
// Expected OAM writes are queued when a transfer is started and compared as the
// DUT writes them; timing is checked relative to the cycle carrying reg_we.
// Build option: OAM_DMA_READBACK_EN selects the expected FF46 read value.
module tb_oam_dma_controller;

    logic        clk;
    logic        reset_n;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        src_read_en;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        oam_we;
    logic [7:0]  oam_waddr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic        busy;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    // Per-run statistics, cleared by start_run().
    int          we_cnt, active_cnt, gap_cnt;
    bit          seen_read, seen_we, seen_active;
    int          first_read_rel, first_we_rel, last_we_rel, first_active_rel, last_active_rel;
    logic [15:0] first_read_addr, last_read_addr;
    logic [7:0]  first_we_addr, last_waddr;
    int          last_read_cyc;
    logic [7:0]  last_read_data;
    logic [7:0]  oam_model [0:255];

`ifdef OAM_DMA_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    oam_dma_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .src_read_en (src_read_en),
        .src_addr    (src_addr),
        .src_rdata   (src_rdata),
        .oam_we      (oam_we),
        .oam_waddr   (oam_waddr),
        .oam_wdata   (oam_wdata),
        .dma_active  (dma_active),
        .busy        (busy)
    );

    // Source memory: every page holds a distinct pattern; page C0 holds i^5A.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9A;
    endfunction

    assign src_rdata = src_byte(src_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic start_run();
        t0          = cyc;
        we_cnt      = 0;
        active_cnt  = 0;
        gap_cnt     = 0;
        seen_read   = 1'b0;
        seen_we     = 1'b0;
        seen_active = 1'b0;
    endtask

    // Expected writes for one full transfer from source page src_page (already folded).
    task automatic push_transfer(input logic [7:0] src_page);
        for (int i = 0; i < 160; i++) begin
            exp_q.push_back('{addr: 8'(i), data: src_byte({src_page, 8'(i)})});
        end
    endtask

    // Observe the current cycle's outputs and run the scoreboard.
    task automatic observe();
        if (busy && !dma_active) gap_cnt++;
        if (dma_active) begin
            if (!seen_active) begin
                first_active_rel = cyc - t0;
                seen_active      = 1'b1;
            end
            last_active_rel = cyc - t0;
            active_cnt++;
        end
        if (src_read_en) begin
            if (!seen_read) begin
                first_read_rel  = cyc - t0;
                first_read_addr = src_addr;
                seen_read       = 1'b1;
            end
            last_read_addr = src_addr;
            last_read_cyc  = cyc;
            last_read_data = src_rdata;
        end
        if (oam_we) begin
            we_cnt++;
            if (!seen_we) begin
                first_we_rel  = cyc - t0;
                first_we_addr = oam_waddr;
                seen_we       = 1'b1;
            end
            last_we_rel = cyc - t0;
            last_waddr  = oam_waddr;
            oam_model[oam_waddr] = oam_wdata;
            check("wdata_vs_src_read", 32'(oam_wdata), 32'(last_read_data));
            check("read_to_write_lag", 32'(cyc - last_read_cyc), 32'd3);
            if (exp_q.size() == 0) begin
                check("unexpected_oam_write", 32'(oam_we), 32'd0);
            end else begin
                exp_t e = exp_q.pop_front();
                check("oam_waddr", 32'(oam_waddr), 32'(e.addr));
                check("oam_wdata", 32'(oam_wdata), 32'(e.data));
            end
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge.
    task automatic step();
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        cyc++;
        observe();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy && n < max_cycles);
        check("idle_within_bound", 32'(busy), 32'd0);
    endtask

    task automatic run_until_writes(input int target, input int max_cycles);
        int n = 0;
        while (we_cnt < target && n < max_cycles) begin
            step();
            n++;
        end
        check("reach_write_count", 32'(we_cnt), 32'(target));
    endtask

    task automatic start_dma(input logic [7:0] page);
        start_run();
        reg_wdata = page;
        reg_we    = 1'b1;
    endtask

    initial begin
        int mism;
        int n;
        int base;

        reset_n   = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = 8'h00;
        for (int i = 0; i < 256; i++) oam_model[i] = 8'h00;
        start_run();
        step();
        step();

        // Reset state.
        check("rst_dma_active", 32'(dma_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oam_we", 32'(oam_we), 32'd0);
        check("rst_src_read_en", 32'(src_read_en), 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        check("rst_reg_rdata", 32'(reg_rdata), READBACK ? 32'h00 : 32'hFF);
        reset_n = 1'b1;
        step();

        // Basic transfer from page C0 with timing relative to the write cycle.
        push_transfer(8'hC0);
        start_dma(8'hC0);
        run_until_idle(1000);
        check("t1_first_active", 32'(first_active_rel), 32'd5);
        check("t1_last_active", 32'(last_active_rel), 32'd644);
        check("t1_active_cycles", 32'(active_cnt), 32'd640);
        check("t1_start_gap", 32'(gap_cnt), 32'd4);
        check("t1_first_read_cyc", 32'(first_read_rel), 32'd5);
        check("t1_first_read_addr", 32'(first_read_addr), 32'hC000);
        check("t1_first_we_cyc", 32'(first_we_rel), 32'd8);
        check("t1_first_we_addr", 32'(first_we_addr), 32'h00);
        check("t1_write_count", 32'(we_cnt), 32'd160);
        check("t1_last_we_cyc", 32'(last_we_rel), 32'd644);
        check("t1_last_waddr", 32'(last_waddr), 32'h9F);
        check("t1_idle_cyc", 32'(cyc - t0), 32'd645);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // OAM contents after the C0 copy.
        mism = 0;
        for (int i = 0; i < 160; i++) begin
            if (oam_model[i] !== (8'(i) ^ 8'h5A)) mism++;
        end
        check("t2_oam_contents_mismatches", 32'(mism), 32'd0);
        check("t2_rdata_after", 32'(reg_rdata), READBACK ? 32'hC0 : 32'hFF);

        // Echo-RAM fold: FE reads page DE.
        step();
        push_transfer(8'hDE);
        start_dma(8'hFE);
        run_until_idle(1000);
        check("t3_fe_first_addr", 32'(first_read_addr), 32'hDE00);
        check("t3_fe_last_addr", 32'(last_read_addr), 32'hDE9F);
        check("t3_fe_writes", 32'(we_cnt), 32'd160);

        // E1 folds to C1.
        step();
        push_transfer(8'hC1);
        start_dma(8'hE1);
        run_until_idle(1000);
        check("t3_e1_first_addr", 32'(first_read_addr), 32'hC100);
        check("t3_e1_last_addr", 32'(last_read_addr), 32'hC19F);

        // Restart with D0 on the second dot of byte 50.
        step();
        push_transfer(8'hC0);
        start_dma(8'hC0);
        run_until_writes(50, 1000);
        step();
        step();
        exp_q.delete();
        push_transfer(8'hD0);
        start_dma(8'hD0);
        run_until_idle(1000);
        check("t4_active_gap", 32'(gap_cnt), 32'd0);
        check("t4_first_read_cyc", 32'(first_read_rel), 32'd5);
        check("t4_first_read_addr", 32'(first_read_addr), 32'hD000);
        check("t4_first_waddr", 32'(first_we_addr), 32'h00);
        check("t4_write_count", 32'(we_cnt), 32'd160);

        // Reset during byte 80, on the dot just before its OAM write.
        step();
        push_transfer(8'hC0);
        start_dma(8'hC0);
        run_until_writes(80, 1000);
        step();
        step();
        step();
        exp_q.delete();
        reset_n = 1'b0;
        step();
        check("t5_oam_we_after_rst", 32'(oam_we), 32'd0);
        check("t5_active_after_rst", 32'(dma_active), 32'd0);
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        reset_n = 1'b1;
        base = we_cnt;
        for (int i = 0; i < 700; i++) step();
        check("t5_no_more_writes", 32'(we_cnt), 32'(base));
        check("t5_reg_rdata", 32'(reg_rdata), READBACK ? 32'h00 : 32'hFF);

        // Write to FF46 during the final OAM write of a transfer.
        push_transfer(8'hC0);
        start_dma(8'hC0);
        n = 0;
        do begin
            step();
            n++;
        end while (!(oam_we && oam_waddr == 8'h9F) && n < 1000);
        check("t6_final_write_seen", 32'(oam_we), 32'd1);
        check("t6_first_xfer_writes", 32'(we_cnt), 32'd160);
        push_transfer(8'h12);
        start_dma(8'h12);
        step();
        check("t6_busy_stays", 32'(busy), 32'd1);
        check("t6_active_stays", 32'(dma_active), 32'd1);
        check("t6_reg_rdata", 32'(reg_rdata), READBACK ? 32'h12 : 32'hFF);
        run_until_idle(1000);
        check("t6_first_read_cyc", 32'(first_read_rel), 32'd5);
        check("t6_first_read_addr", 32'(first_read_addr), 32'h1200);
        check("t6_write_count", 32'(we_cnt), 32'd160);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
